// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: shared widths, R-form funct codes and decode helpers for the HI/LO unit.
package muldiv_sequencer_pkg;
    localparam int XLEN  = 32;
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [5:0] R_FORM  = 6'h00;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    function automatic logic is_muldiv(input logic [5:0] f);
        return f inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
    endfunction

    function automatic logic is_hilo(input logic [5:0] f);
        return is_muldiv(f) || (f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO});
    endfunction
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: shared hi/lo shift pair doing one shift-add multiply or restoring divide step per enable.
module muldiv_iter
    import muldiv_sequencer_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic            load_i,
    input  logic            en_i,
    input  logic            is_div_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);
    // Multiply: hi:lo is the accumulator, lo starts as the multiplier, b_q is the multiplicand.
    // Divide:   hi is the remainder, lo the dividend/quotient, b_q the divisor.
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic            div_q, div_d;
    logic [XLEN:0]   sum, rem_sh, diff;
    logic            take;
    always_comb begin
        sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        rem_sh = {hi_q, lo_q[XLEN-1]};
        diff   = rem_sh - {1'b0, b_q};
        take   = !diff[XLEN];
        hi_d   = load_i ? '0
               : !en_i  ? hi_q
               : div_q  ? (take ? diff[XLEN-1:0] : rem_sh[XLEN-1:0])
               : sum[XLEN:1];
        lo_d   = load_i ? (is_div_i ? a_i : b_i)
               : !en_i  ? lo_q
               : div_q  ? {lo_q[XLEN-2:0], take}
               : {sum[0], lo_q[XLEN-1:1]};
        b_d    = load_i ? (is_div_i ? b_i : a_i) : b_q;
        div_d  = load_i ? is_div_i : div_q;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            b_q   <= b_d;
            div_q <= div_d;
        end
    end
    assign hi_o = hi_q;
    assign lo_o = lo_q;
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO, stalling EX on HI/LO
// access while an operation is in flight.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic            valid,
    input  logic [31:0]     Ins,
    input  logic [XLEN-1:0] Rdata1,
    input  logic [XLEN-1:0] Rdata2,
    output logic [XLEN-1:0] HI,
    output logic [XLEN-1:0] LO,
    output logic            busy,
    output logic            stall
);
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_e;
    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q, div_q, dz_q, neg_q, rneg_q;
    logic [XLEN-1:0]     hi_q, lo_q, a_raw_q;
    logic [5:0]          funct;
    logic                rform, start, sgn, sa, sb;
    logic [XLEN-1:0]     mag_a, mag_b, it_hi, it_lo, quo_fix, rem_fix;
    logic [2*XLEN-1:0]   prod, prod_fix;
    logic                unused_ins;
    always_comb begin
        funct    = Ins[5:0];
        rform    = valid && Ins[31:26] == R_FORM;
        start    = rform && is_muldiv(funct) && state_q == S_IDLE;
        sgn      = funct == F_MULT || funct == F_DIV;
        sa       = sgn && Rdata1[XLEN-1];
        sb       = sgn && Rdata2[XLEN-1];
        mag_a    = sa ? -Rdata1 : Rdata1;
        mag_b    = sb ? -Rdata2 : Rdata2;
        stall    = busy_q && rform && is_hilo(funct);
        prod     = {it_hi, it_lo};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -it_lo : it_lo;
        rem_fix  = rneg_q ? -it_hi : it_hi;
    end
    assign unused_ins = ^Ins[25:6];

    muldiv_iter u_iter (
        .CLK      (CLK),
        .RST      (RST),
        .load_i   (start),
        .en_i     (state_q == S_ITER),
        .is_div_i (funct[1]),
        .a_i      (mag_a),
        .b_i      (mag_b),
        .hi_o     (it_hi),
        .lo_o     (it_lo)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            div_q   <= 1'b0;
            dz_q    <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            a_raw_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (state_q == S_IDLE) begin
            if (start) begin
                state_q <= S_ITER;
                busy_q  <= 1'b1;
                cnt_q   <= '0;
                div_q   <= funct[1];
                dz_q    <= Rdata2 == '0;
                neg_q   <= sa ^ sb;
                rneg_q  <= sa;
                a_raw_q <= Rdata1;
            end else if (rform && funct == F_MTHI) begin
                hi_q <= Rdata1;
            end else if (rform && funct == F_MTLO) begin
                lo_q <= Rdata1;
            end
        end else if (state_q == S_ITER) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) state_q <= S_FIX;
        end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            // Divide by zero bypasses the datapath result: HI keeps the raw dividend.
            if (div_q) begin
                hi_q <= dz_q ? a_raw_q : rem_fix;
                lo_q <= dz_q ? '1 : quo_fix;
            end else begin
                {hi_q, lo_q} <= prod_fix;
            end
        end
    end
    assign HI   = hi_q;
    assign LO   = lo_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and randomized checks of muldiv_sequencer against an arithmetic model.
module tb_muldiv_sequencer;
    localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13;
    localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1A, DIVU = 6'h1B;

    logic        CLK = 0, RST = 1, valid = 0, busy, stall;
    logic [31:0] Ins = 0, Rdata1 = 0, Rdata2 = 0, HI, LO;
    int          vectors = 0, miscompares = 0;

    muldiv_sequencer dut (
        .CLK(CLK), .RST(RST), .valid(valid), .Ins(Ins), .Rdata1(Rdata1), .Rdata2(Rdata2),
        .HI(HI), .LO(LO), .busy(busy), .stall(stall)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (f == MULTU) return {32'h0, a} * {32'h0, b};
        if (f == MULT) begin
            p = sa * sb;
            return p;
        end
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (f == DIVU) return {a % b, a / b};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [31:0] rins(input logic [5:0] f);
        return {6'h00, 20'($urandom), f};
    endfunction

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] e;
        int n;
        e = model(f, a, b);
        valid = 1; Ins = rins(f); Rdata1 = a; Rdata2 = b;
        tick;
        valid = 0; Rdata1 = $urandom; Rdata2 = $urandom;
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick;
        end
        check({tag, "_busy_cycles"}, n, 33);
        check({tag, "_hi"}, HI, e[63:32]);
        check({tag, "_lo"}, LO, e[31:0]);
    endtask

    initial begin
        logic [5:0]  ops [4] = '{MULT, MULTU, DIV, DIVU};
        logic [31:0] hv, a, b;
        int n;
        tick; tick;
        check("reset_hi", HI, 0);
        check("reset_lo", LO, 0);
        check("reset_busy", busy, 0);
        RST = 0;
        valid = 1; Ins = rins(MFHI); #1;
        check("idle_no_stall", stall, 0);
        valid = 0;

        run_op(MULT, 32'hFFFF_FFFE, 32'h3, "mult_neg2x3");
        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_m1xm1");
        run_op(DIV, 32'hFFFF_FFF9, 32'h2, "div_m7_2");
        run_op(DIVU, 32'h7, 32'h2, "divu_7_2");
        run_op(DIVU, 32'h1234_5678, 32'h0, "divu_by0");
        run_op(DIV, 32'h8765_4321, 32'h0, "div_by0");
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(DIV, 32'h0000_0007, 32'hFFFF_FFFE, "div_7_m2");

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'h0 : ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            run_op(ops[$urandom_range(0, 3)], a, b, "rand");
        end

        valid = 1; Ins = rins(MTLO); Rdata1 = 32'h1357_9BDF;
        tick;
        check("mtlo_idle", LO, 32'h1357_9BDF);
        hv = HI;
        Ins = {6'h08, 20'h0, MTHI}; Rdata1 = 32'hDEAD_BEEF;
        tick;
        check("mthi_not_rform", HI, hv);
        valid = 0; Ins = rins(MTHI);
        tick;
        check("mthi_not_valid", HI, hv);

        valid = 1; Ins = rins(MULT); Rdata1 = 32'd1000; Rdata2 = 32'hFFFF_FFFD;
        tick;
        valid = 0;
        repeat (4) tick;
        valid = 1; Ins = rins(MFLO); #1;
        n = 0;
        while (busy && n < 100) begin
            check("stall_mflo", stall, 1);
            n++;
            tick;
        end
        check("mflo_wait_cycles", n, 29);
        check("stall_mflo_released", stall, 0);
        check("mult_1000xm3_lo", LO, 32'hFFFF_F448);
        check("mult_1000xm3_hi", HI, 32'hFFFF_FFFF);

        hv = HI;
        Ins = rins(DIVU); Rdata1 = 32'd100; Rdata2 = 32'd7;
        tick;
        Ins = rins(MTHI); Rdata1 = 32'hCAFE_F00D; #1;
        n = 0;
        while (busy && n < 100) begin
            check("stall_mthi", stall, 1);
            check("mthi_blocked_hi", HI, hv);
            n++;
            tick;
        end
        check("stall_mthi_released", stall, 0);
        check("divu_100_7_hi", HI, 2);
        check("divu_100_7_lo", LO, 14);
        tick;
        check("mthi_after_busy", HI, 32'hCAFE_F00D);
        check("mthi_keeps_lo", LO, 14);
        check("mthi_no_busy", busy, 0);

        Ins = rins(DIV); Rdata1 = 32'h7654_3210; Rdata2 = 32'h0000_0123;
        tick;
        valid = 0;
        repeat (11) tick;
        RST = 1; valid = 1; Ins = rins(MFLO);
        tick;
        RST = 0; #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_hi", HI, 0);
        check("rst_mid_lo", LO, 0);
        check("rst_mid_stall", stall, 0);
        valid = 0;
        repeat (40) tick;
        check("rst_mid_hi_stays", HI, 0);
        run_op(MULT, 32'd6, 32'd7, "mult_6x7");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
